if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  IF-stage producer feeding the IF/ID pipeline register: owns the PC, issues instruction
//  memory reads over a req/ready + rvalid handshake, and presents pc_f/instr_f/valid_f.
//  Honours the decode-stage enable (en_d) as back-pressure and branch/jump redirects from D/E.
//  Emits a NOP bubble whenever no fetched instruction is held.
// PARAMETERS
//  PC_RESET   32'h0000_3000  PC value loaded on reset
//  ADDR_W     32             width of PC and imem_addr
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       synchronous, active-high
//  en_d            in   1       IF/ID enable; instruction consumed when valid_f && en_d
//  redirect_valid  in   1       branch/jump taken; load redirect_pc
//  redirect_pc     in   ADDR_W  redirect target
//  imem_req        out  1       read request valid
//  imem_addr       out  ADDR_W  read address (= pc_q)
//  imem_ready      in   1       memory accepts request this cycle
//  imem_rvalid     in   1       read data valid (exactly one per accepted request)
//  imem_rdata      in   32      instruction word
//  pc_f            out  ADDR_W  PC of presented instruction
//  instr_f         out  32      instruction, 32'h0 (NOP) when valid_f=0
//  valid_f         out  1       instr_f holds a real fetched instruction
// BEHAVIOUR
//  - Reset: pc_q=PC_RESET, state=S_REQ, drop_q=0, instr_q=0; outputs: imem_req=1 from the
//    first post-reset cycle, valid_f=0, instr_f=0, pc_f=PC_RESET. Memory shares this reset;
//    rvalid outside S_WAIT is ignored.
//  - At most one outstanding request. pc_f=pc_q always; imem_addr=pc_q.
//  - States:
//    S_REQ : imem_req=1. imem_ready -> S_WAIT.
//    S_WAIT: imem_req=0. imem_rvalid: drop_q=1 -> clear drop_q, -> S_REQ (data discarded);
//            else instr_q<=imem_rdata, -> S_HOLD.
//    S_HOLD: valid_f=1, instr_f=instr_q. en_d=1 -> pc_q<=pc_q+4, -> S_REQ; en_d=0 -> stay,
//            all outputs stable (stall).
//  - Latency: request issue to valid_f >= 2 cycles; peak throughput 1 instr / 3 cycles with
//    single-cycle memory. No combinational path imem_rdata -> instr_f.
//  - Redirect (priority over everything except reset), pc_q<=redirect_pc in all cases:
//    S_REQ, not accepted: stay S_REQ. S_REQ with imem_ready same cycle: -> S_WAIT, drop_q<=1.
//    S_WAIT (incl. same-cycle rvalid): rvalid same cycle -> discard, -> S_REQ; else drop_q<=1.
//    S_HOLD: held instruction discarded (even if en_d=1 same cycle), -> S_REQ, valid_f<=0.
//  - PC arithmetic: +4 modulo 2^ADDR_W, wrap 32'hFFFF_FFFC -> 0 without error.
//  - Back-to-back redirects: last one wins; drop_q stays a single bit (one outstanding max).
// CONFIGURATION
//  IF_ALIGN_CHECK_EN defined: extra output adel_f (1 bit, reset 0). Redirect to pc[1:0]!=0
//  loads the PC but issues no request: -> S_HOLD with instr_q=0, valid_f=1, adel_f=1
//  (exception carried down the pipe); cleared when consumed or redirected.
//  Not defined: no adel_f port; low PC bits are forwarded unchecked to imem_addr.
// STRUCTURE
//  fetch_pkg: state enum {S_REQ,S_WAIT,S_HOLD}, PC_STEP=4, NOP_INSTR=32'h0, default
//  PC_RESET constant. Sub-module if_next_pc (combinational next-PC mux: redirect / +4 / hold).
//  FSM, pc_q, drop_q, instr_q live in if_fetch_unit.
// TESTING
//  1 reset, 1-cycle mem, en_d=1 -> imem_addr 3000,3004,3008; instr_f matches ROM, pc_f aligned.
//  2 en_d=0 for 5 cycles in S_HOLD -> pc_f/instr_f/valid_f constant, imem_req=0, no new addr.
//  3 redirect_pc=0x3100 while S_WAIT, rvalid 2 cycles later -> old data dropped, next addr 3100.
//  4 redirect same cycle as imem_ready (addr 3004) -> resp discarded, valid_f never shows 3004.
//  5 memory ready delayed 4 cycles, rvalid delayed 3 -> imem_addr held, one request only.
//  6 reset asserted in S_WAIT -> next cycle valid_f=0, pc_f=3000, imem_req=1; with
//    IF_ALIGN_CHECK_EN, redirect to 0x3002 -> valid_f=1, adel_f=1, instr_f=0, no imem_req.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   localparam int unsigned PC_STEP          = 4;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory read port: req/ready request phase plus a single rvalid response.
interface if_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ready;
   logic              imem_rvalid;
   logic [31:0]       imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_next_pc.sv
// Combinational next-PC select: redirect target beats sequential advance, otherwise hold.
module if_next_pc
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              advance,
   input  logic [ADDR_W-1:0] pc_q,
   output logic [ADDR_W-1:0] pc_next
);

   // Sequential advance wraps naturally at the top of the address space.
   always_comb begin
      pc_next = pc_q;
      if (redirect_valid) begin
         pc_next = redirect_pc;
      end else if (advance) begin
         pc_next = pc_q + ADDR_W'(PC_STEP);
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the PC, one outstanding imem read, presents pc_f/instr_f/valid_f.
// Optional IF_ALIGN_CHECK_EN adds adel_f and suppresses fetches from misaligned redirect targets.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_d,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   if_fetch_unit_if.master   imem,
   output logic [ADDR_W-1:0] pc_f,
   output logic [31:0]       instr_f,
`ifdef IF_ALIGN_CHECK_EN
   output logic              valid_f,
   output logic              adel_f
`else
   output logic              valid_f
`endif
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              drop_q, drop_d;
   logic [31:0]       instr_q, instr_d;
   logic              advance;
   logic              redirect_bad;
   logic              pc_bad;

`ifdef IF_ALIGN_CHECK_EN
   logic adel_q, adel_d;
   assign redirect_bad = redirect_valid && is_misaligned(redirect_pc[1:0]);
   assign pc_bad       = is_misaligned(pc_q[1:0]);
`else
   assign redirect_bad = 1'b0;
   assign pc_bad       = 1'b0;
`endif

   assign advance = (state_q == S_HOLD) && en_d;

   if_next_pc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc (
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (advance),
      .pc_q           (pc_q),
      .pc_next        (pc_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= PC_RESET;
         drop_q  <= 1'b0;
         instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         instr_q <= instr_d;
      end
   end

   // A redirect never cancels an accepted request in flight; drop_q marks its response as stale.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      instr_d = instr_q;
      unique case (state_q)
         S_REQ: begin
            if (imem.imem_ready) begin
               state_d = S_WAIT;
               if (redirect_valid) begin
                  drop_d = 1'b1;
               end
            end else if (redirect_bad) begin
               state_d = S_HOLD;
               instr_d = NOP_INSTR;
            end
         end
         S_WAIT: begin
            if (imem.imem_rvalid) begin
               drop_d = 1'b0;
               if (redirect_valid) begin
                  state_d = redirect_bad ? S_HOLD : S_REQ;
                  instr_d = NOP_INSTR;
               end else if (drop_q) begin
                  state_d = pc_bad ? S_HOLD : S_REQ;
                  instr_d = NOP_INSTR;
               end else begin
                  state_d = S_HOLD;
                  instr_d = imem.imem_rdata;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               state_d = redirect_bad ? S_HOLD : S_REQ;
               instr_d = NOP_INSTR;
            end else if (en_d) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
            drop_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      imem.imem_req  = 1'b0;
      imem.imem_addr = pc_q;
      pc_f           = pc_q;
      valid_f        = 1'b0;
      instr_f        = NOP_INSTR;
      unique case (state_q)
         S_REQ:   imem.imem_req = 1'b1;
         S_HOLD: begin
            valid_f = 1'b1;
            instr_f = instr_q;
         end
         default: ;
      endcase
   end

`ifdef IF_ALIGN_CHECK_EN
   // The fault flag rides with the HOLD slot it was raised for and dies with it.
   always_comb begin
      adel_d = adel_q;
      if (redirect_valid) begin
         adel_d = redirect_bad && (state_d == S_HOLD);
      end else if ((state_q == S_WAIT) && imem.imem_rvalid && drop_q) begin
         adel_d = pc_bad;
      end else if (advance) begin
         adel_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         adel_q <= 1'b0;
      end else begin
         adel_q <= adel_d;
      end
   end

   assign adel_f = adel_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a negedge-driven instruction memory model.
module tb_if_fetch_unit;

   logic        clk;
   logic        reset;
   logic        en_d;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc_f;
   logic [31:0] instr_f;
   logic        valid_f;
`ifdef IF_ALIGN_CHECK_EN
   logic        adel_f;
`endif

   if_fetch_unit_if #(.ADDR_W(32)) imem_bus ();

   if_fetch_unit #(
      .ADDR_W   (32),
      .PC_RESET (32'h0000_3000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .en_d           (en_d),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem_bus.master),
      .pc_f           (pc_f),
      .instr_f        (instr_f),
`ifdef IF_ALIGN_CHECK_EN
      .valid_f        (valid_f),
      .adel_f         (adel_f)
`else
      .valid_f        (valid_f)
`endif
   );

   int check_count = 0;
   int fail_count  = 0;

   int          ready_delay = 0;
   int          rvalid_delay = 0;
   int          mem_acc_cnt = 0;
   int          mem_wait_cnt = 0;
   int          req_count = 0;
   logic        mem_pending = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] acc_log[$];
   int          acc_rd = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   // Memory decides its inputs on the falling edge from what the DUT is presenting.
   initial begin
      imem_bus.imem_ready  = 1'b0;
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         imem_bus.imem_ready  = 1'b0;
         imem_bus.imem_rvalid = 1'b0;
         imem_bus.imem_rdata  = 32'h0;
         if (reset) begin
            mem_pending  = 1'b0;
            mem_acc_cnt  = 0;
            mem_wait_cnt = 0;
         end else if (mem_pending) begin
            if (mem_wait_cnt == 0) begin
               imem_bus.imem_rvalid = 1'b1;
               imem_bus.imem_rdata  = rom_word(mem_addr);
               mem_pending          = 1'b0;
            end else begin
               mem_wait_cnt--;
            end
         end else if (imem_bus.imem_req) begin
            if (mem_acc_cnt >= ready_delay) begin
               imem_bus.imem_ready = 1'b1;
               mem_pending         = 1'b1;
               mem_wait_cnt        = rvalid_delay;
               mem_addr            = imem_bus.imem_addr;
               mem_acc_cnt         = 0;
               req_count++;
               acc_log.push_back(imem_bus.imem_addr);
            end else begin
               mem_acc_cnt++;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic rv, input logic [31:0] rpc);
      en_d           = en;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   task automatic waitValid(input string tag, output int lat);
      lat = 0;
      for (int i = 0; i < 30; i++) begin
         if (valid_f) break;
         step();
         lat++;
      end
      checkOutput({tag, "_valid"}, 32'(valid_f), 32'h1);
   endtask

   task automatic expectAccept(input string tag, input logic [31:0] expected);
      logic [31:0] obs;
      obs = (acc_log.size() > acc_rd) ? acc_log[acc_rd] : 32'hDEAD_DEAD;
      acc_rd++;
      checkOutput(tag, obs, expected);
   endtask

   task automatic expectFetch(input string tag, input logic [31:0] pc);
      checkOutput({tag, "_pc"}, pc_f, pc);
      checkOutput({tag, "_instr"}, instr_f, rom_word(pc));
   endtask

   initial begin
      int          lat;
      int          req_before;
      logic [31:0] exp_pc;

      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0);
      step();
      step();
      $display("[TB] reset state");
      checkOutput("rst_valid", 32'(valid_f), 32'h0);
      checkOutput("rst_instr", instr_f, 32'h0);
      checkOutput("rst_pc", pc_f, 32'h0000_3000);
      checkOutput("rst_req", 32'(imem_bus.imem_req), 32'h1);
      reset = 1'b0;

      $display("[TB] sequential fetch");
      for (int k = 0; k < 3; k++) begin
         exp_pc = 32'h0000_3000 + 32'(4 * k);
         waitValid("seq", lat);
         checkOutput("seq_latency", 32'(lat), 32'd2);
         expectFetch("seq", exp_pc);
         expectAccept("seq_addr", exp_pc);
         step();
      end

      $display("[TB] decode stall");
      applyStimulus(1'b0, 1'b0, 32'h0);
      waitValid("stall", lat);
      req_before = req_count;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("stall_valid", 32'(valid_f), 32'h1);
         expectFetch("stall", 32'h0000_300C);
         checkOutput("stall_req", 32'(imem_bus.imem_req), 32'h0);
      end
      checkOutput("stall_reqcnt", 32'(req_count), 32'(req_before));
      expectAccept("stall_addr", 32'h0000_300C);
      applyStimulus(1'b1, 1'b0, 32'h0);
      step();

      $display("[TB] redirect while waiting");
      rvalid_delay = 2;
      step();
      checkOutput("rw_in_wait", 32'(imem_bus.imem_req), 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0000_3100);
      step();
      applyStimulus(1'b1, 1'b0, 32'h0);
      rvalid_delay = 0;
      checkOutput("rw_pc", pc_f, 32'h0000_3100);
      checkOutput("rw_valid0", 32'(valid_f), 32'h0);
      waitValid("rw", lat);
      expectFetch("rw", 32'h0000_3100);
      expectAccept("rw_old_addr", 32'h0000_3010);
      expectAccept("rw_new_addr", 32'h0000_3100);
      step();

      $display("[TB] redirect on accept");
      checkOutput("ra_req", 32'(imem_bus.imem_req), 32'h1);
      applyStimulus(1'b1, 1'b1, 32'h0000_3200);
      step();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("ra_in_wait", 32'(imem_bus.imem_req), 32'h0);
      checkOutput("ra_pc", pc_f, 32'h0000_3200);
      waitValid("ra", lat);
      expectFetch("ra", 32'h0000_3200);
      expectAccept("ra_old_addr", 32'h0000_3104);
      expectAccept("ra_new_addr", 32'h0000_3200);
      step();

      $display("[TB] slow memory");
      ready_delay  = 4;
      rvalid_delay = 3;
      req_before   = req_count;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("slow_req", 32'(imem_bus.imem_req), 32'h1);
         checkOutput("slow_addr", imem_bus.imem_addr, 32'h0000_3204);
      end
      waitValid("slow", lat);
      expectFetch("slow", 32'h0000_3204);
      checkOutput("slow_reqcnt", 32'(req_count), 32'(req_before + 1));
      expectAccept("slow_acc", 32'h0000_3204);
      ready_delay  = 0;
      rvalid_delay = 0;
      step();

      $display("[TB] reset in wait");
      step();
      checkOutput("rs_in_wait", 32'(imem_bus.imem_req), 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("rs_valid", 32'(valid_f), 32'h0);
      checkOutput("rs_pc", pc_f, 32'h0000_3000);
      checkOutput("rs_req", 32'(imem_bus.imem_req), 32'h1);
      checkOutput("rs_instr", instr_f, 32'h0);
      expectAccept("rs_old_addr", 32'h0000_3208);
      waitValid("rs", lat);
      checkOutput("rs_latency", 32'(lat), 32'd2);
      expectFetch("rs", 32'h0000_3000);
      expectAccept("rs_new_addr", 32'h0000_3000);

      $display("[TB] redirect from hold and PC wrap");
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
      step();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("wrap_valid0", 32'(valid_f), 32'h0);
      checkOutput("wrap_pc", pc_f, 32'hFFFF_FFFC);
      checkOutput("wrap_req", 32'(imem_bus.imem_req), 32'h1);
      waitValid("wrap_top", lat);
      expectFetch("wrap_top", 32'hFFFF_FFFC);
      expectAccept("wrap_top_addr", 32'hFFFF_FFFC);
      step();
      checkOutput("wrap_zero_pc", pc_f, 32'h0);
      waitValid("wrap_zero", lat);
      expectFetch("wrap_zero", 32'h0);
      expectAccept("wrap_zero_addr", 32'h0);

      $display("[TB] misaligned redirect");
      req_before = req_count;
      applyStimulus(1'b1, 1'b1, 32'h0000_3002);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef IF_ALIGN_CHECK_EN
      checkOutput("adel_valid", 32'(valid_f), 32'h1);
      checkOutput("adel_flag", 32'(adel_f), 32'h1);
      checkOutput("adel_instr", instr_f, 32'h0);
      checkOutput("adel_req", 32'(imem_bus.imem_req), 32'h0);
      checkOutput("adel_pc", pc_f, 32'h0000_3002);
      step();
      checkOutput("adel_hold_flag", 32'(adel_f), 32'h1);
      checkOutput("adel_hold_req", 32'(imem_bus.imem_req), 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      step();
      checkOutput("adel_clear", 32'(adel_f), 32'h0);
      checkOutput("adel_reqcnt", 32'(req_count), 32'(req_before));
`else
      applyStimulus(1'b1, 1'b0, 32'h0);
      waitValid("mis", lat);
      expectFetch("mis", 32'h0000_3002);
      expectAccept("mis_addr", 32'h0000_3002);
      checkOutput("mis_reqcnt", 32'(req_count), 32'(req_before + 1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
